// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register of the RV32IM core.
// Captures decoded operands and control from ID and presents them to EX one clock later.
// A flush or a load-use bubble loads a NOP; a stall holds the current contents.
// Keeps a saturating count of inserted load-use bubbles.
// Optional feature, macro ID_EX_WB_PATCH_EN: while holding, a retiring writeback
// that targets ex_rs1/ex_rs2 overwrites the held operand data.
module id_ex_stage_register #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               bubble_enable,
    input  logic               stall,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [6:0]         id_ctrl,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [6:0]         ex_ctrl,
    output logic               ex_is_load,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam int unsigned MEM_READ_BIT = 5;

    // A flush or a bubble both replace the ID instruction with a NOP
    logic load_nop;
    assign load_nop = flush | bubble_enable;

`ifdef ID_EX_WB_PATCH_EN
    // Writeback hits on the held source registers (x0 is never patched)
    logic patch_rs1;
    logic patch_rs2;
    assign patch_rs1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1);
    assign patch_rs2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2);
`else
    // Writeback ports are kept for a uniform interface but are not used here
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
`endif

    // Pipeline register: reset > NOP (flush/bubble) > hold > load
    always_ff @(posedge clk) begin
        if (reset || load_nop) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_alu_op   <= '0;
            ex_ctrl     <= '0;
        end else if (stall) begin
`ifdef ID_EX_WB_PATCH_EN
            if (patch_rs1) begin
                ex_rs1_data <= wb_data;
            end
            if (patch_rs2) begin
                ex_rs2_data <= wb_data;
            end
`endif
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_alu_op   <= id_alu_op;
            ex_ctrl     <= id_valid ? id_ctrl : 7'd0;
        end
    end

    // Saturating count of load-use bubbles; a flush in the same cycle suppresses the count
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (!flush && bubble_enable && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

    // Load indication for the hazard unit, taken straight from the registered fields
    assign ex_is_load = ex_ctrl[MEM_READ_BIT] & ex_valid;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Self-checking bench for id_ex_stage_register: directed vector table,
// hand-written stall/patch and saturation sequences, then randomized
// stimulus against a behavioural reference model.
module tb_id_ex_stage_register;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALUOP_W = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;
`ifdef ID_EX_WB_PATCH_EN
    localparam bit PATCH = 1'b1;
`else
    localparam bit PATCH = 1'b0;
`endif

    logic               clk;
    logic               reset, flush, bubble_enable, stall, id_valid;
    logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]         id_rs1, id_rs2, id_rd;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [6:0]         id_ctrl;
    logic               wb_reg_write;
    logic [4:0]         wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               ex_valid;
    logic [XLEN-1:0]    ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]         ex_rs1, ex_rs2, ex_rd;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [6:0]         ex_ctrl;
    logic               ex_is_load;
    logic [CNT_W-1:0]   bubble_count;

    int tests_run = 0;
    int tests_failed = 0;

    id_ex_stage_register #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bubble_enable(bubble_enable),
        .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl),
        .ex_is_load(ex_is_load), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of what EX should hold
    typedef struct {
        bit        v;
        bit [31:0] pc, d1, d2, imm;
        bit [4:0]  rs1, rs2, rd, op;
        bit [6:0]  ctrl;
        int        cnt;
    } model_t;
    model_t m;

    typedef struct {
        bit        rst, fl, bu, st, val;
        bit [31:0] pc, d1;
        bit [4:0]  rs1;
        bit [6:0]  ctrl;
        bit        ev;
        bit [31:0] epc, ed1;
        bit [4:0]  ers1;
        bit [6:0]  ectrl;
        bit        eil;
        int        ecnt;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge, advancing the model from the inputs present at the edge
    task automatic step();
        model_t n;
        n = m;
        if (reset) begin
            n = '{default: 0};
        end else if (flush || bubble_enable) begin
            n = '{default: 0};
            n.cnt = m.cnt;
            if (!flush) n.cnt = (m.cnt < CNT_MAX) ? m.cnt + 1 : CNT_MAX;
        end else if (stall) begin
            if (PATCH && wb_reg_write && wb_rd != 0 && wb_rd == m.rs1) n.d1 = wb_data;
            if (PATCH && wb_reg_write && wb_rd != 0 && wb_rd == m.rs2) n.d2 = wb_data;
        end else begin
            n.v = id_valid; n.pc = id_pc; n.d1 = id_rs1_data; n.d2 = id_rs2_data;
            n.imm = id_imm; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
            n.op = id_alu_op; n.ctrl = id_valid ? id_ctrl : 7'd0;
        end
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
        chk({tag, ".pc"}, ex_pc, m.pc);
        chk({tag, ".rs1_data"}, ex_rs1_data, m.d1);
        chk({tag, ".rs2_data"}, ex_rs2_data, m.d2);
        chk({tag, ".imm"}, ex_imm, m.imm);
        chk({tag, ".regs"}, 32'({ex_rs1, ex_rs2, ex_rd}), 32'({m.rs1, m.rs2, m.rd}));
        chk({tag, ".alu_op"}, 32'(ex_alu_op), 32'(m.op));
        chk({tag, ".ctrl"}, 32'(ex_ctrl), 32'(m.ctrl));
        chk({tag, ".is_load"}, 32'(ex_is_load), 32'(m.ctrl[5] && m.v));
        chk({tag, ".count"}, 32'(bubble_count), 32'(m.cnt));
    endtask

    initial begin
        m = '{default: 0};
        reset = 1'b0; flush = 1'b0; bubble_enable = 1'b0; stall = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = 32'h5555_0000;
        id_imm = 32'h0000_0FFF; id_rs1 = '0; id_rs2 = 5'd6; id_rd = 5'd7;
        id_alu_op = 5'd3; id_ctrl = '0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;

        //            rst fl bu st val pc         d1            rs1   ctrl        ev epc        ed1           ers1  ectrl       il cnt
        tbl[0]  = '{1, 1, 1, 1, 1, 32'h100, 32'hFFFF_FFFF, 5'd31, 7'b1111111, 0, 32'h0,   32'h0,        5'd0, 7'b0000000, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 5'd5,  7'b1000000, 1, 32'h100, 32'hDEAD_BEEF, 5'd5, 7'b1000000, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 32'h104, 32'h11,        5'd3,  7'b0100000, 1, 32'h104, 32'h11,        5'd3, 7'b0100000, 1, 0};
        tbl[3]  = '{0, 0, 1, 0, 1, 32'h108, 32'h22,        5'd7,  7'b1000000, 0, 32'h0,   32'h0,         5'd0, 7'b0000000, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 1, 32'h108, 32'h22,        5'd7,  7'b1000000, 1, 32'h108, 32'h22,        5'd7, 7'b1000000, 0, 1};
        tbl[5]  = '{0, 1, 1, 0, 1, 32'h10C, 32'h66,        5'd8,  7'b1000000, 0, 32'h0,   32'h0,         5'd0, 7'b0000000, 0, 1};
        tbl[6]  = '{0, 0, 1, 1, 1, 32'h10C, 32'h66,        5'd8,  7'b1000000, 0, 32'h0,   32'h0,         5'd0, 7'b0000000, 0, 2};
        tbl[7]  = '{0, 0, 0, 0, 0, 32'h10C, 32'h33,        5'd9,  7'b1111111, 0, 32'h10C, 32'h33,        5'd9, 7'b0000000, 0, 2};
        tbl[8]  = '{0, 0, 0, 0, 1, 32'h110, 32'h44,        5'd5,  7'b0100000, 1, 32'h110, 32'h44,        5'd5, 7'b0100000, 1, 2};
        tbl[9]  = '{0, 0, 0, 1, 1, 32'h200, 32'h77,        5'd2,  7'b1000000, 1, 32'h110, 32'h44,        5'd5, 7'b0100000, 1, 2};
        tbl[10] = '{1, 0, 0, 1, 1, 32'h204, 32'h88,        5'd4,  7'b1000000, 0, 32'h0,   32'h0,         5'd0, 7'b0000000, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 32'h300, 32'h55,        5'd1,  7'b1000000, 1, 32'h300, 32'h55,        5'd1, 7'b1000000, 0, 0};

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; flush = tbl[i].fl; bubble_enable = tbl[i].bu; stall = tbl[i].st;
            id_valid = tbl[i].val; id_pc = tbl[i].pc; id_rs1_data = tbl[i].d1;
            id_rs1 = tbl[i].rs1; id_ctrl = tbl[i].ctrl;
            wb_reg_write = (i == 0); wb_rd = (i == 0) ? 5'd31 : 5'd0;
            wb_data = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
            step();
            chk($sformatf("vec%0d.valid", i), 32'(ex_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.pc", i), ex_pc, tbl[i].epc);
            chk($sformatf("vec%0d.rs1_data", i), ex_rs1_data, tbl[i].ed1);
            chk($sformatf("vec%0d.rs1", i), 32'(ex_rs1), 32'(tbl[i].ers1));
            chk($sformatf("vec%0d.ctrl", i), 32'(ex_ctrl), 32'(tbl[i].ectrl));
            chk($sformatf("vec%0d.is_load", i), 32'(ex_is_load), 32'(tbl[i].eil));
            chk($sformatf("vec%0d.count", i), 32'(bubble_count), 32'(tbl[i].ecnt));
            if (i == 0) begin
                chk("reset.others", 32'(ex_rs2_data | ex_imm | 32'({ex_rs2, ex_rd, ex_alu_op})), 32'h0);
            end
        end
        reset = 1'b0; flush = 1'b0; bubble_enable = 1'b0; stall = 1'b0;

        // Stall hold for three cycles, with writebacks retiring during the hold
        id_valid = 1'b1; id_pc = 32'h400; id_rs1_data = 32'hAAAA_0000; id_rs1 = 5'd5;
        id_rs2_data = 32'hBBBB_0000; id_rs2 = 5'd6; id_ctrl = 7'b1000000;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        step();
        chk("hold.load_pc", ex_pc, 32'h400);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            id_pc = 32'h500 + 32'(c); id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_rs1 = 5'(c + 10); id_ctrl = 7'b0100000;
            wb_reg_write = (c != 1);
            wb_rd = (c == 0) ? 5'd5 : ((c == 1) ? 5'd5 : 5'd6);
            wb_data = (c == 0) ? 32'h1234 : ((c == 1) ? 32'h9999 : 32'h5678);
            step();
            chk($sformatf("hold%0d.pc", c), ex_pc, 32'h400);
            chk($sformatf("hold%0d.rs1", c), 32'(ex_rs1), 32'd5);
            chk($sformatf("hold%0d.ctrl", c), 32'(ex_ctrl), 32'h40);
            chk($sformatf("hold%0d.rs1_data", c), ex_rs1_data, PATCH ? 32'h1234 : 32'hAAAA_0000);
            chk($sformatf("hold%0d.rs2_data", c), ex_rs2_data,
                (PATCH && c == 2) ? 32'h5678 : 32'hBBBB_0000);
        end
        stall = 1'b0; wb_reg_write = 1'b0;
        step();
        chk("release.pc", ex_pc, 32'h502);

        // Saturation: 20 consecutive bubbles on a 4-bit counter
        reset = 1'b1; step(); reset = 1'b0;
        bubble_enable = 1'b1;
        for (int b = 0; b < 20; b++) begin
            step();
            chk($sformatf("sat%0d.count", b), 32'(bubble_count), (b + 1 < 15) ? 32'(b + 1) : 32'd15);
        end
        bubble_enable = 1'b0; id_valid = 1'b1; id_ctrl = 7'b0100000;
        step();
        chk("sat.after_load_is_load", 32'(ex_is_load), 32'd1);
        chk("sat.after_count", 32'(bubble_count), 32'd15);

        // Randomized stimulus against the model
        reset = 1'b1; step();
        check_model("rnd_init");
        for (int r = 0; r < 400; r++) begin
            reset = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            bubble_enable = ($urandom_range(0, 5) == 0);
            stall = ($urandom_range(0, 3) == 0);
            id_valid = $urandom_range(0, 1);
            id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom); id_alu_op = 5'($urandom); id_ctrl = 7'($urandom);
            wb_reg_write = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
            check_model($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- ID/EX pipeline register of the RV32IM core.
- Captures decoded operands and control from ID and presents them to EX.
- Consumes bubble_enable from the load-use hazard unit and inserts a NOP into EX. Also accepts flush (taken branch/jump) and stall (multi-cycle M-unit busy).
- Keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 5, ALU opcode field width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  kill ID instruction, load NOP
bubble_enable  in  1  load-use bubble request, load NOP
stall  in  1  hold current contents
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register file read port 1
id_rs2_data  in  XLEN  register file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  5 each  register addresses
id_alu_op  in  ALUOP_W  ALU/MUL operation select
id_ctrl  in  7  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
wb_reg_write  in  1  WB stage writes register file
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB write data
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  out  5 each  registered copies
ex_alu_op  out  ALUOP_W  registered copy
ex_ctrl  out  7  registered copy
ex_is_load  out  1  equals ex_ctrl[5] (mem_read) & ex_valid; drives IsLoad of the hazard unit
bubble_count  out  CNT_W  number of bubbles inserted

Behaviour:
- Reset, synchronous and active-high on posedge clk. All outputs go to 0: ex_valid=0, ex_ctrl=0, all data and address fields 0, bubble_count=0.
- Per-edge priority: reset > flush > bubble_enable > stall > load.
- flush=1: load NOP. ex_valid=0, ex_ctrl=0, ex_alu_op=0, ex_rd=0. Data fields don't-care; the implementation drives 0. bubble_count unchanged.
- bubble_enable=1 (flush=0): load NOP as for flush, and increment bubble_count. Upstream PC and IF/ID hold externally.
- stall=1 with no flush or bubble: every field holds its value.
- Otherwise, load: every ex_* field takes the matching id_* input; ex_valid takes id_valid.
- If id_valid=0 on a load, the block forces ex_ctrl=0, so a non-valid instruction never writes.
- Latency: one clock, ID to EX.
- Simultaneous flush and bubble_enable: flush wins; bubble_count is not incremented.
- Simultaneous bubble_enable and stall: bubble wins.
- bubble_count saturates at all-ones and does not wrap.
- ex_is_load is combinational from the registered fields; no extra latency.
- Reset asserted mid-stall: contents cleared and the stall is released. After reset deasserts, the first edge with stall=0 loads normally.

Optional Feature:
- Macro: ID_EX_WB_PATCH_EN.
- Defined, while holding (stall=1, no flush, no bubble, no reset): if wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1, ex_rs1_data takes wb_data. ex_rs2 is patched independently under the same rule. Both may be patched in the same cycle.
- This prevents a stalled instruction from missing a writeback that retires during the stall.
- Not defined: holding keeps ex_rs1_data and ex_rs2_data unchanged. The wb_* ports remain present but unused.

Test Plan:
- Reset: drive all inputs nonzero, assert reset for 1 cycle -> all outputs 0, bubble_count=0.
- Normal load: id_valid=1, id_pc=0x100, id_rs1_data=0xDEADBEEF, id_ctrl=7'b1000000, stall/flush/bubble=0 -> after one edge ex_pc=0x100, ex_rs1_data=0xDEADBEEF, ex_valid=1, ex_is_load=0.
- Load-use bubble: ex_is_load=1, then bubble_enable=1 for one cycle -> ex_valid=0, ex_ctrl=0, bubble_count 0->1. Next edge with bubble_enable=0 loads the held ID instruction.
- Priority: flush=1 and bubble_enable=1 together -> NOP loaded, bubble_count unchanged. stall=1 and bubble_enable=1 -> NOP loaded, count+1.
- Stall hold: load ex_rs1=5, then stall=1 for 3 cycles while id_* change -> outputs constant. With ID_EX_WB_PATCH_EN and wb_reg_write=1, wb_rd=5, wb_data=0x1234 during the stall -> ex_rs1_data=0x1234. With wb_rd=0 -> unchanged.
- Saturation: CNT_W=4, 20 consecutive bubbles -> bubble_count=15 and stays 15.
